decode_buffer: RTL and testbench
================================

DECODE_BUFFER -- requirements
Module: decode_buffer

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of buffered instructions; legal values are powers of 2 from 2 to 16.
REQ-002 Parameter PC_W, default 16, SHALL set the width of the PC carried with each instruction.
REQ-003 Ports SHALL be as follows, in this order:
- clk  in  1  rising-edge clock, the only clock
- rst  in  1  asynchronous, active-low reset
- inst_valid  in  1  fetch presents an instruction
- inst  in  16  instruction word
- pc  in  PC_W  PC of inst
- inst_ready  out  1  buffer accepts the instruction
- flush  in  1  discard all buffered state
- ix_ready  in  1  execute accepts the head entry
- dec_valid  out  1  head entry present
- dec_pc  out  PC_W  PC of head
- dec_opcode  out  5  head inst[15:11]
- dec_rs  out  3  head inst[10:8]
- dec_rt  out  3  head inst[7:5]
- dec_rd  out  3  destination register
- dec_imm  out  16  extended immediate
- dec_class  out  3  instruction class
- dec_illegal  out  1  head is an illegal-op (00010)
- count  out  $clog2(DEPTH)+1  occupancy
- halted  out  1  a HALT has retired

Function
REQ-004 The block SHALL be a circular FIFO of {inst, pc} entries with write and read pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
REQ-005 All dec_* outputs SHALL be combinational decodes of the head entry; they are don't-care when dec_valid=0.
REQ-006 Enqueue SHALL occur when inst_valid & inst_ready; dequeue SHALL occur when dec_valid & ix_ready.
REQ-007 inst_ready SHALL equal (count<DEPTH) & (state==RUN); there is no full bypass, so a full buffer with a same-cycle dequeue still holds inst_ready=0.
REQ-008 dec_valid SHALL equal (count!=0) & (state!=HALTED); there is no empty bypass, so an enqueued entry is first visible the cycle after enqueue.
REQ-009 A simultaneous enqueue and dequeue SHALL leave count unchanged and advance both pointers.
REQ-010 dec_class SHALL encode: 0 for opcodes 000xx; 1 for 001xx (jump); 2 for 011xx (branch); 3 for 010xx and 101xx (ALU immediate); 4 for 100xx except 10010 (memory); 5 for 10010, 11000, 11001 and 1101x (ALU/byte/register); 6 for 111xx (compare).
REQ-011 dec_rd SHALL be:
- inst[7:5] for 010xx, 101xx and 100xx except 10010
- inst[10:8] for 10010 and 11000
- inst[4:2] for 11001, 1101x and 111xx
- 3'd7 for 0011x
- 0 otherwise
REQ-012 dec_imm SHALL be:
- zero-extended inst[7:0] for 10010
- zero-extended inst[4:0] for 01010, 01011 and 101xx
- sign-extended inst[10:0] for 00100 and 00110
- sign-extended inst[4:0] for 01000, 01001 and 100xx except 10010
- sign-extended inst[7:0] otherwise
REQ-013 The state machine SHALL have three states, RUN, DRAIN and HALTED, with these transitions:
- RUN to DRAIN when an enqueued inst has opcode 00000
- DRAIN to HALTED when the dequeued head has opcode 00000
- HALTED holds until flush or reset
REQ-014 halted SHALL be 1 exactly when state==HALTED.
REQ-015 A HALT enqueued into an empty buffer and dequeued in a later cycle SHALL follow the RUN, DRAIN, HALTED sequence normally.
REQ-016 flush SHALL, on the next clock edge, zero both pointers and count and force state to RUN, overriding any same-cycle enqueue, dequeue or state transition; inst_ready is not gated by flush.
REQ-017 The block SHALL perform no arithmetic beyond pointer and count increments; count SHALL never exceed DEPTH or fall below 0.

Reset
REQ-018 While rst=0, the block SHALL asynchronously hold pointers=0, count=0 and state=RUN, giving inst_ready=1, dec_valid=0 and halted=0.
REQ-019 FIFO storage SHALL not require reset.
REQ-020 Reset asserted mid-operation SHALL discard all entries with no partial dequeue.
REQ-021 The first enqueue after reset SHALL be permitted on the first rising edge after rst deasserts.

Verification
REQ-022 Scenario: enqueue ADDI 0x4125 (01000 001 001 00101) at pc 0x0010 with ix_ready=0 -> next cycle dec_valid=1, dec_class=3, dec_rs=1, dec_rd=1, dec_imm=0x0005, count=1.
REQ-023 Scenario: with DEPTH=4 and ix_ready=0, present 5 instructions -> count=4, inst_ready=0, 5th held; then ix_ready=1 with inst_valid=1 -> count stays 4 for one cycle, then accepts.
REQ-024 Scenario: enqueue J 0x27FF (00100, disp 0x7FF) -> dec_imm=0xFFFF, dec_class=1; enqueue JAL 0x3001 -> dec_rd=7, dec_imm=0x0001.
REQ-025 Scenario: enqueue NOP, HALT(0x0000), NOP -> inst_ready=0 after HALT and the 3rd word is not taken; dequeue NOP then HALT -> halted=1, dec_valid=0.
REQ-026 Scenario: with count=3, assert flush together with inst_valid and ix_ready -> next cycle count=0, dec_valid=0, state=RUN, and neither the incoming nor the head entry is consumed.
REQ-027 Scenario: run 20 enqueue/dequeue pairs with DEPTH=4 -> pointers wrap and entries emerge in order with matching dec_pc.

Source files
------------

// File: rtl/decode_buffer.sv
// Decode buffer: circular FIFO of {inst, pc} between fetch and execute, with a
// combinational decode of the head entry and a RUN/DRAIN/HALTED halt sequencer.
module decode_buffer #(
   parameter int DEPTH = 4,
   parameter int PC_W  = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   inst_valid,
   input  logic [15:0]            inst,
   input  logic [PC_W-1:0]        pc,
   output logic                   inst_ready,
   input  logic                   flush,
   input  logic                   ix_ready,
   output logic                   dec_valid,
   output logic [PC_W-1:0]        dec_pc,
   output logic [4:0]             dec_opcode,
   output logic [2:0]             dec_rs,
   output logic [2:0]             dec_rt,
   output logic [2:0]             dec_rd,
   output logic [15:0]            dec_imm,
   output logic [2:0]             dec_class,
   output logic                   dec_illegal,
   output logic [$clog2(DEPTH):0] count,
   output logic                   halted
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [4:0] OP_HALT    = 5'b00000;
   localparam logic [4:0] OP_ILLEGAL = 5'b00010;

   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

   state_t           state_q, state_d;
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count_q;
   logic [15:0]      inst_mem [DEPTH];
   logic [PC_W-1:0]  pc_mem   [DEPTH];
   logic [15:0]      head_inst;
   logic             enq, deq;

   function automatic logic [2:0] class_of(input logic [4:0] op);
      logic [2:0] c;
      casez (op)
         5'b000??:                        c = 3'd0;
         5'b001??:                        c = 3'd1;
         5'b011??:                        c = 3'd2;
         5'b010??, 5'b101??:              c = 3'd3;
         5'b10010:                        c = 3'd5;
         5'b100??:                        c = 3'd4;
         5'b11000, 5'b11001, 5'b1101?:    c = 3'd5;
         default:                         c = 3'd6;
      endcase
      return c;
   endfunction

   // f carries inst[10:2]: rs field at [8:6], rt at [5:3], low field at [2:0]
   function automatic logic [2:0] rd_of(input logic [4:0] op, input logic [8:0] f);
      logic [2:0] r;
      casez (op)
         5'b10010, 5'b11000:                      r = f[8:6];
         5'b010??, 5'b101??, 5'b100??:            r = f[5:3];
         5'b11001, 5'b1101?, 5'b111??:            r = f[2:0];
         5'b0011?:                                r = 3'd7;
         default:                                 r = 3'd0;
      endcase
      return r;
   endfunction

   function automatic logic [15:0] imm_of(input logic [4:0] op, input logic [10:0] f);
      logic signed [15:0] ext;
      casez (op)
         5'b10010:           ext = $signed({8'd0, f[7:0]});
         5'b0101?, 5'b101??: ext = $signed({11'd0, f[4:0]});
         5'b001?0:           ext = 16'($signed(f[10:0]));
         5'b0100?, 5'b100??: ext = 16'($signed(f[4:0]));
         default:            ext = 16'($signed(f[7:0]));
      endcase
      return $unsigned(ext);
   endfunction

   assign head_inst   = inst_mem[rd_ptr];
   assign inst_ready  = (count_q < CNT_W'(DEPTH)) && (state_q == RUN);
   assign dec_valid   = (count_q != '0) && (state_q != HALTED);
   assign enq         = inst_valid && inst_ready;
   assign deq         = dec_valid && ix_ready;

   assign dec_pc      = pc_mem[rd_ptr];
   assign dec_opcode  = head_inst[15:11];
   assign dec_rs      = head_inst[10:8];
   assign dec_rt      = head_inst[7:5];
   assign dec_rd      = rd_of(head_inst[15:11], head_inst[10:2]);
   assign dec_imm     = imm_of(head_inst[15:11], head_inst[10:0]);
   assign dec_class   = class_of(head_inst[15:11]);
   assign dec_illegal = (head_inst[15:11] == OP_ILLEGAL);
   assign count       = count_q;
   assign halted      = (state_q == HALTED);

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (enq && inst[15:11] == OP_HALT) state_d = DRAIN;
         DRAIN:   if (deq && head_inst[15:11] == OP_HALT) state_d = HALTED;
         HALTED:  state_d = HALTED;
         default: state_d = RUN;
      endcase
      if (flush) state_d = RUN;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= RUN;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else if (flush) begin
         state_q <= RUN;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
         if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
         if (enq && !deq)      count_q <= count_q + CNT_W'(1);
         else if (deq && !enq) count_q <= count_q - CNT_W'(1);
      end
   end

   // Storage is data only; stale slots are unreachable once pointers reset
   always_ff @(posedge clk) begin
      if (enq) begin
         inst_mem[wr_ptr] <= inst;
         pc_mem[wr_ptr]   <= pc;
      end
   end

endmodule

// File: tb/tb_decode_buffer.sv
// Bench for decode_buffer: directed scenarios plus random traffic, checked by a
// queue-based reference model and a negedge monitor.
module tb_decode_buffer;

   localparam int DEPTH = 4;
   localparam int PC_W  = 16;
   localparam int M_RUN = 0, M_DRAIN = 1, M_HALT = 2;

   logic                   clk = 1'b0;
   logic                   rst, inst_valid, flush, ix_ready;
   logic [15:0]            inst;
   logic [PC_W-1:0]        pc;
   logic                   inst_ready, dec_valid, dec_illegal, halted;
   logic [PC_W-1:0]        dec_pc;
   logic [4:0]             dec_opcode;
   logic [2:0]             dec_rs, dec_rt, dec_rd, dec_class;
   logic [15:0]            dec_imm;
   logic [$clog2(DEPTH):0] count;

   typedef struct {
      logic [PC_W-1:0] pc;
      logic [4:0]      op;
      logic [2:0]      rs, rt, rd, cls;
      logic [15:0]     imm;
      logic            ill;
   } exp_t;

   exp_t sb[$];
   int   mstate = M_RUN;
   bit   deq_seen = 0, deq_halt = 0;
   int   errors = 0, checks = 0;

   decode_buffer #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
      .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst(inst), .pc(pc),
      .inst_ready(inst_ready), .flush(flush), .ix_ready(ix_ready),
      .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_opcode(dec_opcode),
      .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_rd(dec_rd), .dec_imm(dec_imm),
      .dec_class(dec_class), .dec_illegal(dec_illegal), .count(count),
      .halted(halted)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic int sext(input int v, input int bits);
      return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
   endfunction

   // Reference decode written from the opcode ranges as plain integers
   function automatic exp_t expect_of(input logic [15:0] w, input logic [PC_W-1:0] p);
      exp_t e;
      int   op, imm;
      op    = int'(w[15:11]);
      e.pc  = p;
      e.op  = w[15:11];
      e.rs  = w[10:8];
      e.rt  = w[7:5];
      e.ill = (op == 2);
      if (op < 4)                      e.cls = 3'd0;
      else if (op < 8)                 e.cls = 3'd1;
      else if (op < 12)                e.cls = 3'd3;
      else if (op < 16)                e.cls = 3'd2;
      else if (op < 20)                e.cls = (op == 18) ? 3'd5 : 3'd4;
      else if (op < 24)                e.cls = 3'd3;
      else if (op < 28)                e.cls = 3'd5;
      else                             e.cls = 3'd6;
      if ((op >= 8 && op < 12) || (op >= 20 && op < 24) || (op >= 16 && op < 20 && op != 18))
         e.rd = w[7:5];
      else if (op == 18 || op == 24)   e.rd = w[10:8];
      else if (op >= 25)               e.rd = w[4:2];
      else if (op == 6 || op == 7)     e.rd = 3'd7;
      else                             e.rd = 3'd0;
      if (op == 18)                                        imm = int'(w[7:0]);
      else if (op == 10 || op == 11 || (op >= 20 && op < 24)) imm = int'(w[4:0]);
      else if (op == 4 || op == 6)                         imm = sext(int'(w[10:0]), 11);
      else if (op == 8 || op == 9 || (op >= 16 && op < 20)) imm = sext(int'(w[4:0]), 5);
      else                                                 imm = sext(int'(w[7:0]), 8);
      e.imm = imm[15:0];
      return e;
   endfunction

   // Reference model step at the clock edge, using the pre-edge occupancy
   task automatic model_step();
      int cur, pre;
      if (rst) begin
         cur = mstate;
         pre = sb.size() + int'(deq_seen);
         if (flush) begin
            sb.delete();
            mstate = M_RUN;
         end else begin
            if (cur == M_DRAIN && deq_seen && deq_halt) mstate = M_HALT;
            if (inst_valid && pre < DEPTH && cur == M_RUN) begin
               sb.push_back(expect_of(inst, pc));
               if (inst[15:11] == 5'd0) mstate = M_DRAIN;
            end
         end
      end
      deq_seen = 0;
      deq_halt = 0;
   endtask

   task automatic drive(input bit r, input bit v, input logic [15:0] w,
                        input logic [PC_W-1:0] p, input bit ix, input bit fl);
      rst = r; inst_valid = v; inst = w; pc = p; ix_ready = ix; flush = fl;
      if (!r) begin
         sb.delete();
         mstate = M_RUN;
      end
      @(posedge clk);
      model_step();
      #1;
   endtask

   function automatic logic [15:0] rand_word();
      logic [15:0] w;
      w = 16'($urandom);
      if (w[15:11] == 5'd0) w[15:11] = 5'd3;
      return w;
   endfunction

   always @(negedge clk) begin
      bit   mv, mr;
      exp_t e;
      mv = (sb.size() != 0) && (mstate != M_HALT);
      mr = (sb.size() < DEPTH) && (mstate == M_RUN);
      chk("inst_ready", 32'(inst_ready), 32'(mr));
      chk("dec_valid", 32'(dec_valid), 32'(mv));
      chk("count", 32'(count), 32'(sb.size()));
      chk("halted", 32'(halted), 32'(mstate == M_HALT));
      if (mv && dec_valid) begin
         chk("dec_pc", 32'(dec_pc), 32'(sb[0].pc));
         chk("dec_opcode", 32'(dec_opcode), 32'(sb[0].op));
         chk("dec_rs", 32'(dec_rs), 32'(sb[0].rs));
         chk("dec_rt", 32'(dec_rt), 32'(sb[0].rt));
         chk("dec_rd", 32'(dec_rd), 32'(sb[0].rd));
         chk("dec_imm", 32'(dec_imm), 32'(sb[0].imm));
         chk("dec_class", 32'(dec_class), 32'(sb[0].cls));
         chk("dec_illegal", 32'(dec_illegal), 32'(sb[0].ill));
      end
      if (mv && ix_ready && rst) begin
         e = sb.pop_front();
         deq_seen = 1;
         deq_halt = (e.op == 5'd0);
      end
   end

   initial begin
      logic [15:0] w5;
      logic [15:0] pcv;
      pcv = 16'h0100;
      // reset held, then first enqueue on the edge after release
      for (int i = 0; i < 3; i++) drive(0, 1, 16'h4125, 16'h0010, 1, 0);
      drive(1, 1, 16'h4125, 16'h0010, 0, 0);
      drive(1, 0, 16'h0000, 16'h0000, 0, 0);
      drive(1, 0, 16'h0000, 16'h0000, 0, 1);
      // fill to DEPTH, hold the 5th, then simultaneous dequeue
      for (int i = 0; i < DEPTH; i++) drive(1, 1, rand_word(), 16'h0200 + 16'(i), 0, 0);
      w5 = rand_word();
      drive(1, 1, w5, 16'h0204, 0, 0);
      drive(1, 1, w5, 16'h0204, 1, 0);
      drive(1, 1, w5, 16'h0204, 1, 0);
      for (int i = 0; i < 6; i++) drive(1, 0, 16'h0000, 16'h0000, 1, 0);
      // jump displacement sign extension and JAL link register
      drive(1, 1, 16'h27FF, 16'h0300, 0, 0);
      drive(1, 1, 16'h3001, 16'h0302, 0, 0);
      drive(1, 1, 16'h1234, 16'h0304, 0, 0);
      for (int i = 0; i < 4; i++) drive(1, 0, 16'h0000, 16'h0000, 1, 0);
      // NOP, HALT, NOP: drain then halt
      drive(1, 1, 16'h0800, 16'h0400, 0, 0);
      drive(1, 1, 16'h0000, 16'h0402, 0, 0);
      drive(1, 1, 16'h0800, 16'h0404, 0, 0);
      for (int i = 0; i < 5; i++) drive(1, 1, 16'h0800, 16'h0404, 1, 0);
      drive(1, 0, 16'h0000, 16'h0000, 0, 1);
      // flush with count=3 alongside enqueue and dequeue
      for (int i = 0; i < 3; i++) drive(1, 1, rand_word(), 16'h0500 + 16'(i), 0, 0);
      drive(1, 1, rand_word(), 16'h0510, 1, 1);
      drive(1, 0, 16'h0000, 16'h0000, 0, 0);
      // reset asserted mid-operation
      for (int i = 0; i < 3; i++) drive(1, 1, rand_word(), 16'h0600 + 16'(i), i == 2, 0);
      drive(0, 1, rand_word(), 16'h0610, 1, 0);
      drive(0, 0, 16'h0000, 16'h0000, 1, 0);
      drive(1, 1, 16'h9012, 16'h0620, 0, 0);
      // 20 back-to-back enqueue/dequeue pairs across pointer wrap
      for (int i = 0; i < 20; i++) drive(1, 1, rand_word(), 16'h0700 + 16'(2 * i), 1, 0);
      for (int i = 0; i < 3; i++) drive(1, 0, 16'h0000, 16'h0000, 1, 0);
      // random traffic, including occasional HALT words and flushes
      for (int i = 0; i < 1500; i++) begin
         logic [15:0] w;
         w = 16'($urandom);
         if (w[15:11] == 5'd0 && $urandom_range(0, 3) != 0) w[15:11] = 5'd18;
         drive(1, $urandom_range(0, 3) != 0, w, pcv, $urandom_range(0, 2) != 0,
               $urandom_range(0, 39) == 0);
         pcv = pcv + 16'd2;
      end
      drive(1, 0, 16'h0000, 16'h0000, 0, 1);
      drive(1, 0, 16'h0000, 16'h0000, 0, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
